// File: rtl/fe_fb_if.sv
// fe_fb_if: front-end fetch, flush and memory refill signals of the fetch buffer.
interface fe_fb_if #(
    parameter int PADDR_W    = 32,
    parameter int LINE_BYTES = 16
);
    logic                    fe_fb_req_valid;
    logic [PADDR_W-1:0]      fe_fb_req_addr;
    logic                    fb_fe_rsp_valid;
    logic [31:0]             fb_fe_rsp_instr;
    logic [PADDR_W-1:0]      fb_fe_rsp_pc;
    logic                    br_mispred_rb1;
    logic                    fb_mem_req_valid;
    logic [PADDR_W-1:0]      fb_mem_req_addr;
    logic                    fb_mem_req_ready;
    logic                    mem_fb_rsp_valid;
    logic [LINE_BYTES*8-1:0] mem_fb_rsp_data;

    modport slave (
        input  fe_fb_req_valid, fe_fb_req_addr, br_mispred_rb1,
        input  fb_mem_req_ready, mem_fb_rsp_valid, mem_fb_rsp_data,
        output fb_fe_rsp_valid, fb_fe_rsp_instr, fb_fe_rsp_pc,
        output fb_mem_req_valid, fb_mem_req_addr
    );

    modport master (
        output fe_fb_req_valid, fe_fb_req_addr, br_mispred_rb1,
        output fb_mem_req_ready, mem_fb_rsp_valid, mem_fb_rsp_data,
        input  fb_fe_rsp_valid, fb_fe_rsp_instr, fb_fe_rsp_pc,
        input  fb_mem_req_valid, fb_mem_req_addr
    );
endinterface

// File: rtl/fe_fb.sv
// fe_fb: fetch buffer with a fully-associative line cache and single-outstanding refill.
// Optional FB_PERF_CNT_EN adds saturating hit/miss counters.
module fe_fb #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_BYTES = 16,
    parameter int PADDR_W    = 32
) (
    input  logic clk,
    input  logic reset,
    fe_fb_if.slave bus
`ifdef FB_PERF_CNT_EN
    ,
    output logic [31:0] fb_hit_cnt,
    output logic [31:0] fb_miss_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = PADDR_W - OFF_W;
    localparam int PTR_W  = $clog2(NUM_LINES);
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, FILL} state_t;

    state_t             state, state_nx;
    logic [NUM_LINES-1:0] vld;
    logic [TAG_W-1:0]   tags  [NUM_LINES];
    logic [LINE_W-1:0]  lines [NUM_LINES];
    logic [PTR_W-1:0]   rr_ptr, victim;
    logic [PADDR_W-1:0] cap_addr, pend_addr, look_addr, rsp_pc;
    logic [LINE_W-1:0]  hit_line;
    logic [31:0]        rsp_instr;
    logic               orphan, pend, look, hit, rsp_valid, fill;

    function automatic logic [31:0] word_of(input logic [LINE_W-1:0] l, input logic [PADDR_W-1:0] a);
        logic [OFF_W-1:0] w;
        w = a[OFF_W-1:0] >> 2;
        return l[32*w +: 32];
    endfunction

    // A pending request (held while orphaned) is looked up in FILL, so it can hit the line just written.
    always_comb begin
        look_addr = (state == FILL && pend) ? pend_addr : bus.fe_fb_req_addr;
        look      = !bus.br_mispred_rb1 && (state == IDLE ? bus.fe_fb_req_valid :
                    state == FILL && (pend || (orphan && bus.fe_fb_req_valid)));
        hit       = 1'b0;
        hit_line  = '0;
        for (int i = 0; i < NUM_LINES; i++)
            if (vld[i] && tags[i] == look_addr[PADDR_W-1:OFF_W]) begin
                hit      = 1'b1;
                hit_line = lines[i];
            end
    end

    assign fill = state == MISS_WAIT && bus.mem_fb_rsp_valid;

    always_comb begin
        state_nx = state;
        if (look)
            state_nx = hit ? IDLE : MISS_REQ;
        else if (state == MISS_REQ)
            state_nx = bus.fb_mem_req_ready ? MISS_WAIT : MISS_REQ;
        else if (fill)
            state_nx = FILL;
        else if (state == FILL)
            state_nx = IDLE;
    end

    assign bus.fb_mem_req_valid = state == MISS_REQ;
    assign bus.fb_mem_req_addr  = {cap_addr[PADDR_W-1:OFF_W], OFF_W'(0)};
    assign bus.fb_fe_rsp_valid  = rsp_valid && !(state == FILL && bus.br_mispred_rb1);
    assign bus.fb_fe_rsp_instr  = rsp_instr;
    assign bus.fb_fe_rsp_pc     = rsp_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vld       <= '0;
            rr_ptr    <= '0;
            victim    <= '0;
            cap_addr  <= '0;
            pend_addr <= '0;
            orphan    <= 1'b0;
            pend      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_pc    <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            if (look && hit) begin
                rsp_valid <= 1'b1;
                rsp_instr <= word_of(hit_line, look_addr);
                rsp_pc    <= look_addr;
            end
            if (look && !hit) begin
                cap_addr <= look_addr;
                victim   <= rr_ptr;
                rr_ptr   <= rr_ptr + 1'b1;
            end
            if (fill) begin
                vld[victim]   <= 1'b1;
                tags[victim]  <= cap_addr[PADDR_W-1:OFF_W];
                lines[victim] <= bus.mem_fb_rsp_data;
                rsp_valid     <= !orphan && !bus.br_mispred_rb1;
                rsp_instr     <= word_of(bus.mem_fb_rsp_data, cap_addr);
                rsp_pc        <= cap_addr;
            end
            if (state == FILL)
                orphan <= 1'b0;
            else if (bus.br_mispred_rb1 && (state == MISS_REQ || state == MISS_WAIT))
                orphan <= 1'b1;
            if (bus.br_mispred_rb1 || state == FILL)
                pend <= 1'b0;
            else if (orphan && !pend && bus.fe_fb_req_valid && state != IDLE) begin
                pend      <= 1'b1;
                pend_addr <= bus.fe_fb_req_addr;
            end
        end
    end

`ifdef FB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_hit_cnt  <= '0;
            fb_miss_cnt <= '0;
        end else begin
            if (look && hit && !(&fb_hit_cnt))
                fb_hit_cnt <= fb_hit_cnt + 1'b1;
            if (look && !hit && !(&fb_miss_cnt))
                fb_miss_cnt <= fb_miss_cnt + 1'b1;
        end
    end
`endif

`ifdef ASSERT
    wire busy = state == MISS_REQ || state == MISS_WAIT;
    a_no_req_in_refill: assert property (@(posedge clk) disable iff (reset)
        !(bus.fe_fb_req_valid && !bus.br_mispred_rb1 && busy && !orphan));
    a_one_pending: assert property (@(posedge clk) disable iff (reset)
        !(bus.fe_fb_req_valid && !bus.br_mispred_rb1 && busy && pend));
`endif
endmodule

// File: tb/tb_fe_fb.sv
// tb_fe_fb: directed and randomized fetch traffic checked against a FIFO-of-resident-lines model.
module tb_fe_fb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fe_fb_if bus ();
`ifdef FB_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    fe_fb dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FB_PERF_CNT_EN
        ,
        .fb_hit_cnt(hit_cnt),
        .fb_miss_cnt(miss_cnt)
`endif
    );

    int n_run = 0;
    int n_fail = 0;
    int m_hit = 0;
    int m_miss = 0;
    logic [31:0] resident[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h104 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word({a[31:4], 4'h0} + 32'(4 * i));
        return l;
    endfunction

    function automatic bit is_res(input logic [31:0] a);
        foreach (resident[i]) if (resident[i] == (a >> 4)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_fill(input logic [31:0] a);
        resident.push_back(a >> 4);
        if (resident.size() > 4) void'(resident.pop_front());
        m_miss++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resident.delete();
        m_hit = 0;
        m_miss = 0;
    endtask

    task automatic fetch(input logic [31:0] a, input int rd, input int wd);
        bit h;
        h = is_res(a);
        bus.fe_fb_req_valid = 1'b1;
        bus.fe_fb_req_addr  = a;
        tick();
        bus.fe_fb_req_valid = 1'b0;
        if (h) begin
            m_hit++;
            chk("hit_valid", bus.fb_fe_rsp_valid, 1);
            chk("hit_instr", bus.fb_fe_rsp_instr, mem_word(a & ~32'h3));
            chk("hit_pc", bus.fb_fe_rsp_pc, a);
            chk("hit_no_mem", bus.fb_mem_req_valid, 0);
        end else begin
            chk("miss_no_rsp", bus.fb_fe_rsp_valid, 0);
            for (int r = 0; r <= rd; r++) begin
                chk("mreq_valid", bus.fb_mem_req_valid, 1);
                chk("mreq_addr", bus.fb_mem_req_addr, a & ~32'hF);
                if (r == rd) bus.fb_mem_req_ready = 1'b1;
                tick();
            end
            bus.fb_mem_req_ready = 1'b0;
            chk("mreq_single", bus.fb_mem_req_valid, 0);
            for (int w = 0; w < wd; w++) begin
                chk("wait_no_rsp", bus.fb_fe_rsp_valid, 0);
                tick();
            end
            bus.mem_fb_rsp_valid = 1'b1;
            bus.mem_fb_rsp_data  = line_of(a);
            tick();
            bus.mem_fb_rsp_valid = 1'b0;
            chk("fill_valid", bus.fb_fe_rsp_valid, 1);
            chk("fill_instr", bus.fb_fe_rsp_instr, mem_word(a & ~32'h3));
            chk("fill_pc", bus.fb_fe_rsp_pc, a);
            model_fill(a);
            tick();
            chk("post_fill_quiet", bus.fb_fe_rsp_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] a;
        bus.fe_fb_req_valid  = 1'b0;
        bus.fe_fb_req_addr   = '0;
        bus.br_mispred_rb1   = 1'b0;
        bus.fb_mem_req_ready = 1'b0;
        bus.mem_fb_rsp_valid = 1'b0;
        bus.mem_fb_rsp_data  = '0;
        reset = 1'b1;
        tick();
        do_reset();
        chk("rst_rsp_valid", bus.fb_fe_rsp_valid, 0);
        chk("rst_rsp_instr", bus.fb_fe_rsp_instr, 0);
        chk("rst_rsp_pc", bus.fb_fe_rsp_pc, 0);
        chk("rst_mreq_valid", bus.fb_mem_req_valid, 0);
        chk("rst_mreq_addr", bus.fb_mem_req_addr, 0);

        fetch(32'h100, 0, 0);
        fetch(32'h104, 0, 0);
        fetch(32'h108, 0, 0);
        fetch(32'h10C, 0, 0);
        fetch(32'h200, 5, 2);

        // orphaned refill with a pending request that hits the refilled line
        bus.fe_fb_req_valid = 1'b1;
        bus.fe_fb_req_addr  = 32'h300;
        tick();
        bus.fe_fb_req_valid = 1'b0;
        chk("fl_mreq_valid", bus.fb_mem_req_valid, 1);
        chk("fl_mreq_addr", bus.fb_mem_req_addr, 32'h300);
        bus.fb_mem_req_ready = 1'b1;
        tick();
        bus.fb_mem_req_ready = 1'b0;
        bus.br_mispred_rb1   = 1'b1;
        tick();
        bus.br_mispred_rb1  = 1'b0;
        bus.fe_fb_req_valid = 1'b1;
        bus.fe_fb_req_addr  = 32'h304;
        tick();
        bus.fe_fb_req_valid = 1'b0;
        chk("fl_wait_quiet", bus.fb_fe_rsp_valid, 0);
        bus.mem_fb_rsp_valid = 1'b1;
        bus.mem_fb_rsp_data  = line_of(32'h300);
        tick();
        bus.mem_fb_rsp_valid = 1'b0;
        chk("fl_orphan_suppressed", bus.fb_fe_rsp_valid, 0);
        model_fill(32'h300);
        tick();
        m_hit++;
        chk("fl_pend_valid", bus.fb_fe_rsp_valid, 1);
        chk("fl_pend_instr", bus.fb_fe_rsp_instr, mem_word(32'h304));
        chk("fl_pend_pc", bus.fb_fe_rsp_pc, 32'h304);
        chk("fl_pend_no_mem", bus.fb_mem_req_valid, 0);
        tick();
        chk("fl_quiet", bus.fb_fe_rsp_valid, 0);

        do_reset();
        for (int i = 0; i < 5; i++) fetch(32'(16 * i), 1, 1);
        fetch(32'h0, 0, 0);

        // reset while the refill is outstanding; the late line must be dropped
        bus.fe_fb_req_valid = 1'b1;
        bus.fe_fb_req_addr  = 32'h500;
        tick();
        bus.fe_fb_req_valid  = 1'b0;
        bus.fb_mem_req_ready = 1'b1;
        tick();
        bus.fb_mem_req_ready = 1'b0;
        do_reset();
        bus.mem_fb_rsp_valid = 1'b1;
        bus.mem_fb_rsp_data  = line_of(32'h500);
        tick();
        bus.mem_fb_rsp_valid = 1'b0;
        chk("late_rsp_ignored", bus.fb_fe_rsp_valid, 0);
        chk("late_no_mreq", bus.fb_mem_req_valid, 0);
        tick();
        chk("late_still_quiet", bus.fb_fe_rsp_valid, 0);
        fetch(32'h100, 1, 1);

        for (int k = 0; k < 150; k++) begin
            a = 32'h1000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                bus.fe_fb_req_valid = 1'b1;
                bus.fe_fb_req_addr  = a;
                bus.br_mispred_rb1  = 1'b1;
                tick();
                bus.fe_fb_req_valid = 1'b0;
                bus.br_mispred_rb1  = 1'b0;
                chk("flush_discard_rsp", bus.fb_fe_rsp_valid, 0);
                chk("flush_discard_mem", bus.fb_mem_req_valid, 0);
            end else begin
                fetch(a, $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
`ifdef FB_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, 128'(m_hit));
        chk("miss_cnt", miss_cnt, 128'(m_miss));
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fe_fb.md
Name: fe_fb

Overview:
Fetch buffer directly upstream of the front-end controller.
- Services the single-outstanding instruction request `fe_fb_req_nnn` and returns one 32-bit instruction on `fb_fe_rsp_nnn`.
- Holds a small fully-associative cache of instruction lines.
- Refills misses from the memory subsystem over a valid/ready request channel and a valid-only response channel.
- Absorbs branch-mispredict flushes without losing or corrupting an in-flight refill.

Parameters:
NUM_LINES, 4, number of line entries (power of 2, >=2)
LINE_BYTES, 16, bytes per line (power of 2, >=4); instructions per line = LINE_BYTES/4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fe_fb_req_nnn  in  t_fe_fb_req  fetch request {valid, addr(t_paddr), id}
fb_fe_rsp_nnn  out  t_fb_fe_rsp  fetch response {valid, instr(t_rv_instr), pc(t_paddr)}
br_mispred_rb1  in  1  flush; cancels any response owed to the front end
fb_mem_req_valid  out  1  line refill request valid
fb_mem_req_addr  out  t_paddr  line-aligned refill address
fb_mem_req_ready  in  1  memory accepts request
mem_fb_rsp_valid  in  1  refill data valid (exactly one per accepted request)
mem_fb_rsp_data  in  LINE_BYTES*8  refill line, byte 0 in bits [7:0]

Behaviour:
Reset (one clock, synchronous):
- All line valid bits clear.
- FSM goes to IDLE; orphan and pending flags clear; replacement pointer = 0.
- `fb_fe_rsp_nnn` = '0; `fb_mem_req_valid` = 0; addr = 0.
- Reset mid-refill: state is dropped. The memory response may still arrive; it must be ignored while in IDLE with orphan=0.

Lookup:
- Performed combinationally in the cycle the request is accepted.
- Tag = `addr[PADDR_W-1:log2(LINE_BYTES)]`; word select = `addr[log2(LINE_BYTES)-1:2]`.
- `addr[1:0]` is ignored.

Hit:
- `fb_fe_rsp_nnn.valid` = 1 the next cycle (1-cycle latency), carrying instr = selected word and pc = request addr.
- Valid is a 1-cycle pulse. There is no backpressure; the front end captures it.

Request acceptance:
- Accepted when the FSM is IDLE, including the cycle in which a response is driven, so back-to-back hits sustain 1 instr/clk.
- A request arriving in MISS_REQ/MISS_WAIT with orphan=0 is a protocol violation; assert under ASSERT.

FSM states: IDLE, MISS_REQ, MISS_WAIT, FILL.
- IDLE -> MISS_REQ on accepted miss. Capture addr and the victim (replacement pointer), then increment the pointer modulo NUM_LINES.
- MISS_REQ: drive `fb_mem_req_valid`=1 with the line-aligned address. Hold until `fb_mem_req_ready`, then go to MISS_WAIT.
- MISS_WAIT: on `mem_fb_rsp_valid`, write data, tag and valid into the victim, then go to FILL.
- FILL: drive the response from the filled line (word from captured addr), unless orphan. Go to IDLE.
- Miss latency: response one cycle after `mem_fb_rsp_valid`.

Flush (`br_mispred_rb1`=1):
- Any response due next cycle is suppressed.
- A request in the same cycle as the flush is discarded.
- In MISS_REQ/MISS_WAIT, set orphan. The refill still completes and writes the line, but the FILL response is suppressed.
- While orphan=1, one new request is held in a 1-entry pending register; a second new request is an assertion error.
- On FILL with pending=1, the pending request is looked up in FILL (may hit the just-written line). The FSM proceeds as if the request were accepted in IDLE.
- A flush in FILL suppresses that cycle's response and clears pending.

Replacement and invalidation:
- Round-robin replacement. A tag that is already present is never duplicated: a miss cannot be for a resident tag.
- No invalidation other than reset.

Optional Feature:
FB_PERF_CNT_EN
- Defined: adds outputs `fb_hit_cnt` and `fb_miss_cnt`, 32 bits each.
  - Each increments by 1 per accepted non-discarded lookup, hit or miss respectively.
  - Saturate at 0xFFFF_FFFF; cleared by reset.
- Undefined: ports and counters absent; otherwise identical behaviour.

Test Plan:
- Reset, then request addr 0x100 → `fb_mem_req_valid`=1, addr 0x100. Ready same cycle; rsp data word1=0xDEADBEEF at cycle T → `fb_fe_rsp_nnn` valid at T+1, pc 0x100, instr = word0.
- After the fill, requests 0x104, 0x108, 0x10C back-to-back → three consecutive 1-cycle-latency hits, no memory request.
- Miss 0x200 with `fb_mem_req_ready` held low 5 cycles → valid/addr stable for all 5 cycles. Single request issued.
- Miss 0x300, flush in MISS_WAIT, new request 0x304 next cycle, memory returns → no response for 0x300. 0x304 served as a hit at fill+1.
- Fill 5 distinct lines 0x0, 0x10, 0x20, 0x30, 0x40 (NUM_LINES=4), then request 0x0 → miss (evicted), memory request 0x0.
- Reset asserted during MISS_WAIT, then late `mem_fb_rsp_valid` → no response; request 0x100 misses.
